// File: rtl/prbs9_ber_checker.sv
// PRBS9 (x^9 + x^5 + 1) bit-error-rate checker: self-synchronises to the received stream and counts bits/errors while locked.
// Define BER_CHECK_LOL_CNT_EN to build the loss-of-lock event counter; otherwise lol_count is tied to zero.
module prbs9_ber_checker #(
   parameter int WINDOW  = 64,
   parameter int ERR_THR = 4,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             rx_in,
   input  logic             clear,
   output logic             lock,
   output logic [CNT_W-1:0] bit_count,
   output logic [CNT_W-1:0] err_count,
   output logic [15:0]      lol_count
);

   localparam int WB_W = $clog2(WINDOW) + 1;
   localparam logic [WB_W-1:0] WINDOW_W  = WB_W'(WINDOW);
   localparam logic [WB_W-1:0] ERR_THR_W = WB_W'(ERR_THR);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [8:0]       lfsr_q, lfsr_d;
   logic [3:0]       fill_q, fill_d;
   logic [WB_W-1:0]  win_bits_q, win_bits_d;
   logic [WB_W-1:0]  win_errs_q, win_errs_d;
   logic             lock_q, lock_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic             pred_bit;
   logic             mism;
   logic [8:0]       shift_rx;
   logic [8:0]       shift_pred;
   logic [WB_W-1:0]  win_bits_inc;
   logic [WB_W-1:0]  win_errs_inc;
   logic             win_end;
   logic             win_bad;

   assign pred_bit     = lfsr_q[8] ^ lfsr_q[4];
   assign mism         = rx_in ^ pred_bit;
   assign shift_rx     = {lfsr_q[7:0], rx_in};
   // Once synchronised the LFSR runs on its own prediction, so a channel error is counted only once.
   assign shift_pred   = {lfsr_q[7:0], pred_bit};
   assign win_bits_inc = win_bits_q + 1'b1;
   assign win_errs_inc = win_errs_q + {{(WB_W-1){1'b0}}, mism};
   assign win_end      = (win_bits_inc == WINDOW_W);
   assign win_bad      = (win_errs_inc > ERR_THR_W);

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      fill_d     = fill_q;
      win_bits_d = win_bits_q;
      win_errs_d = win_errs_q;
      lock_d     = lock_q;
      bit_cnt_d  = bit_cnt_q;
      err_cnt_d  = err_cnt_q;

      if (enable) begin
         case (state_q)
            ST_HUNT: begin
               lfsr_d = shift_rx;
               if (fill_q == 4'd8) begin
                  fill_d = 4'd0;
                  // An all-zero seed would lock onto a dead line, so refill instead.
                  if (shift_rx != 9'd0) begin
                     state_d    = ST_CHECK;
                     win_bits_d = '0;
                     win_errs_d = '0;
                  end
               end else begin
                  fill_d = fill_q + 4'd1;
               end
            end

            ST_CHECK: begin
               lfsr_d     = shift_pred;
               win_bits_d = win_bits_inc;
               win_errs_d = win_errs_inc;
               if (win_bad) begin
                  state_d = ST_HUNT;
                  fill_d  = 4'd0;
               end else if (win_end) begin
                  state_d    = ST_LOCKED;
                  lock_d     = 1'b1;
                  win_bits_d = '0;
                  win_errs_d = '0;
               end
            end

            ST_LOCKED: begin
               lfsr_d     = shift_pred;
               win_bits_d = win_bits_inc;
               win_errs_d = win_errs_inc;
               if (bit_cnt_q != {CNT_W{1'b1}}) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
               if (mism && (err_cnt_q != {CNT_W{1'b1}})) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
               // Lock is only re-qualified at window boundaries.
               if (win_end) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
                  if (win_bad) begin
                     state_d = ST_HUNT;
                     lock_d  = 1'b0;
                     fill_d  = 4'd0;
                  end
               end
            end

            default: begin
               state_d = ST_HUNT;
               lock_d  = 1'b0;
               fill_d  = 4'd0;
            end
         endcase
      end

      if (clear) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_HUNT;
         lfsr_q     <= 9'd0;
         fill_q     <= 4'd0;
         win_bits_q <= '0;
         win_errs_q <= '0;
         lock_q     <= 1'b0;
         bit_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         fill_q     <= fill_d;
         win_bits_q <= win_bits_d;
         win_errs_q <= win_errs_d;
         lock_q     <= lock_d;
         bit_cnt_q  <= bit_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign lock      = lock_q;
   assign bit_count = bit_cnt_q;
   assign err_count = err_cnt_q;

`ifdef BER_CHECK_LOL_CNT_EN
   logic        lol_event;
   logic [15:0] lol_cnt_q, lol_cnt_d;

   assign lol_event = enable && (state_q == ST_LOCKED) && win_end && win_bad;

   always_comb begin
      lol_cnt_d = lol_cnt_q;
      if (clear) begin
         lol_cnt_d = 16'd0;
      end else if (lol_event && (lol_cnt_q != 16'hFFFF)) begin
         lol_cnt_d = lol_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lol_cnt_q <= 16'd0;
      end else begin
         lol_cnt_q <= lol_cnt_d;
      end
   end

   assign lol_count = lol_cnt_q;
`else
   assign lol_count = 16'd0;
`endif

endmodule
